// File: rtl/uart_receiver.sv
// 8N1 UART receive path: synchronizes rx, detects the start edge, and majority-votes
// each bit at its centre using OVERSAMPLE sample ticks per bit.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       rx_busy
);

  // state | meaning
  // IDLE  | waiting for a high-to-low transition on rx_s
  // START | timing the start bit, false-start check at bit end
  // DATA  | shifting in 8 voted data bits, LSB first
  // STOP  | stop-bit vote at MID+1, then strobe and return to IDLE
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] MID_M = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_C = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] MID_P = CW'(OVERSAMPLE / 2 + 1);

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   prev_s, prev_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [2:0]             bit_idx, bit_idx_nx;
  logic [7:0]             shreg, shreg_nx;
  logic [2:0]             smp, smp_nx;
  logic [7:0]             data_nx;
  logic                   valid_nx, ferr_nx;
  logic                   third, vote;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // The stop decision happens on the MID+1 tick itself, so the third sample is live.
  assign third   = (cnt == MID_P) ? rx_s : smp[2];
  assign vote    = (smp[0] & smp[1]) | (smp[0] & third) | (smp[1] & third);
  assign rx_busy = (state != IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q      <= '1;
      state       <= IDLE;
      prev_s      <= 1'b1;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      smp         <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rx};
      state       <= state_nx;
      prev_s      <= prev_nx;
      cnt         <= cnt_nx;
      bit_idx     <= bit_idx_nx;
      shreg       <= shreg_nx;
      smp         <= smp_nx;
      data_out    <= data_nx;
      data_valid  <= valid_nx;
      framing_err <= ferr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    prev_nx    = prev_s;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    smp_nx     = smp;
    data_nx    = data_out;
    valid_nx   = 1'b0;
    ferr_nx    = 1'b0;

    if (sample_tick) begin
      prev_nx = rx_s;
      cnt_nx  = (cnt == LAST) ? '0 : cnt + CW'(1);
      if (cnt == MID_M) smp_nx[0] = rx_s;
      if (cnt == MID_C) smp_nx[1] = rx_s;
      if (cnt == MID_P) smp_nx[2] = rx_s;

      case (state)
        IDLE: begin
          cnt_nx = '0;
          // The detecting tick counts as sample 0 of the start bit.
          if (prev_s && !rx_s) begin
            state_nx = START;
            cnt_nx   = CW'(1);
          end
        end
        START: begin
          if (cnt == LAST) begin
            bit_idx_nx = '0;
            state_nx   = vote ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            shreg_nx = {vote, shreg[7:1]};
            if (bit_idx == 3'd7) state_nx = STOP;
            else                 bit_idx_nx = bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (cnt == MID_P) begin
            if (vote) begin
              data_nx  = shreg;
              valid_nx = 1'b1;
            end else begin
              ferr_nx  = 1'b1;
            end
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: stimulus pushes expected bytes/errors into a queue,
// an independent monitor pops and compares on every data_valid / framing_err strobe.
module tb_uart_receiver;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       rx_busy;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;
  int   period_x10 = 540;
  int   phase = 0;
  logic prev_strobe = 1'b0;

  uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sample_tick (sample_tick),
    .rx          (rx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk_in = ~clk_in;

  // Fractional tick generator: average tick period is period_x10/10 clocks.
  always @(negedge clk_in) begin
    phase = phase + 10;
    if (phase >= period_x10) begin
      phase = phase - period_x10;
      sample_tick = 1'b1;
    end else begin
      sample_tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (data_valid || framing_err) begin
        check("strobe_exclusive", 32'(data_valid & framing_err), 32'd0);
        check("strobe_one_cycle", 32'(prev_strobe), 32'd0);
        check("busy_low_at_strobe", 32'(rx_busy), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_strobe: actual valid=%0b ferr=%0b data=%0h required none",
                   data_valid, framing_err, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind_ferr", 32'(framing_err), 32'(mon_e.ferr));
          check("data_out", 32'(data_out), 32'(mon_e.data));
        end
      end
      prev_strobe = data_valid | framing_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic wait_tick();
    int guard = 0;
    do begin
      @(posedge clk_in);
      guard++;
    end while (!sample_tick && guard < 400);
    if (!sample_tick) begin
      n_checks++;
      $display("FAIL tick_timeout: actual no tick in %0d clocks required a tick", guard);
    end
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // Tick-aligned frame; gpos/mask invert chosen samples of one bit, rpos pulses reset
  // at sample 8 of that frame position (0 = start bit, 9 = stop bit).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gpos,
                            input logic [15:0] mask, input int rpos);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    wait_tick();
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 16; c++) begin
        rx = frame[p] ^ ((p == gpos) && mask[c]);
        if (p == rpos && c == 8) begin
          @(negedge clk_in);
          rst_in = 1'b1;
          @(negedge clk_in);
          rst_in = 1'b0;
          check("rst_data_out", 32'(data_out), 32'h00);
          check("rst_rx_busy", 32'(rx_busy), 32'd0);
          check("rst_data_valid", 32'(data_valid), 32'd0);
          check("rst_framing_err", 32'(framing_err), 32'd0);
        end
        wait_tick();
      end
    end
  endtask

  // Clock-timed frame, independent of the receiver's tick rate.
  task automatic send_frame_clk(input logic [7:0] b, input int bit_clks);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int p = 0; p < 10; p++) begin
      @(negedge clk_in);
      rx = frame[p];
      repeat (bit_clks - 1) @(negedge clk_in);
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20000) begin
      @(negedge clk_in);
      guard++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: actual still running at 3 ms required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_framing_err", 32'(framing_err), 32'd0);
    check("reset_rx_busy", 32'(rx_busy), 32'd0);
    rst_in = 1'b0;
    wait_ticks(4);

    // 0xA5 at 54 clocks per tick
    exp_q.push_back('{ferr: 1'b0, data: 8'hA5});
    send_frame(8'hA5, 1'b1, -1, 16'h0, -1);
    wait_ticks(4);
    drain("drain_a5");
    check("busy_after_a5", 32'(rx_busy), 32'd0);

    period_x10 = 100;
    wait_ticks(4);

    // false start: 4 low ticks
    wait_tick();
    rx = 1'b0;
    wait_ticks(4);
    check("busy_in_false_start", 32'(rx_busy), 32'd1);
    rx = 1'b1;
    wait_ticks(20);
    check("idle_after_false_start", 32'(rx_busy), 32'd0);
    exp_q.push_back('{ferr: 1'b0, data: 8'h3C});
    send_frame(8'h3C, 1'b1, -1, 16'h0, -1);
    wait_ticks(2);
    drain("drain_3c");

    // stop bit low, then a held break must not re-arm
    exp_q.push_back('{ferr: 1'b1, data: 8'h3C});
    send_frame(8'h55, 1'b0, -1, 16'h0, -1);
    wait_ticks(40);
    check("break_no_rearm", 32'(rx_busy), 32'd0);
    drain("drain_ferr");
    rx = 1'b1;
    wait_ticks(2);

    // data bit 3 (frame position 4) glitched on one, then two vote samples
    exp_q.push_back('{ferr: 1'b0, data: 8'h00});
    send_frame(8'h00, 1'b1, 4, 16'h0100, -1);
    wait_ticks(2);
    drain("drain_glitch1");
    exp_q.push_back('{ferr: 1'b0, data: 8'h08});
    send_frame(8'h00, 1'b1, 4, 16'h0180, -1);
    wait_ticks(2);
    drain("drain_glitch2");

    // back-to-back frames with receiver ticks about 3% slow
    period_x10 = 103;
    exp_q.push_back('{ferr: 1'b0, data: 8'h00});
    exp_q.push_back('{ferr: 1'b0, data: 8'hFF});
    exp_q.push_back('{ferr: 1'b0, data: 8'h81});
    send_frame_clk(8'h00, 160);
    send_frame_clk(8'hFF, 160);
    send_frame_clk(8'h81, 160);
    @(negedge clk_in);
    rx = 1'b1;
    repeat (200) @(negedge clk_in);
    drain("drain_b2b");
    period_x10 = 100;
    wait_ticks(2);

    // reset mid data bit 4; all-ones remainder leaves no falling edge behind
    send_frame(8'hFF, 1'b1, -1, 16'h0, 5);
    wait_ticks(4);
    check("no_strobe_after_reset", 32'(exp_q.size()), 32'd0);
    exp_q.push_back('{ferr: 1'b0, data: 8'hC3});
    send_frame(8'hC3, 1'b1, -1, 16'h0, -1);
    wait_ticks(2);
    drain("drain_c3");

    // byte sweep at a fast tick rate
    period_x10 = 40;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{ferr: 1'b0, data: 8'(k * 17)});
      send_frame(8'(k * 17), 1'b1, -1, 16'h0, -1);
    end
    wait_ticks(4);
    drain("drain_sweep");
    check("final_busy", 32'(rx_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
